// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the load/store unit (master) and data_mem_ctrl (slave).
interface data_mem_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_fault;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RV32 data memory: byte/half/word loads and stores, registered one-cycle response, fault reporting.
// Define DMEM_MISALIGN_SPLIT_EN to service word-spanning accesses over two cycles instead of faulting.
module data_mem_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    data_mem_ctrl_if.slave bus
);
    localparam int IDXW = $clog2(MEM_WORDS);

`ifdef DMEM_MISALIGN_SPLIT_EN
    typedef enum logic [0:0] {IDLE = 1'b0, SPLIT = 1'b1} state_t;
`else
    typedef enum logic [0:0] {IDLE = 1'b0} state_t;
`endif

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic                  ready_q, in_split, accept;
    logic [1:0]            lane, size;
    logic [IDXW-1:0]       idx;
    logic [ADDR_WIDTH-1:0] addr_hi;
    logic                  bad_op, out_of_range, crosses, misalign, span, next_oob, fault, go_split;
    logic [3:0]            size_mask;
    logic [7:0]            be8;
    logic [63:0]           wdata64;

    logic                  split_we, split_uns;
    logic [1:0]            split_lane, split_size;
    logic [IDXW-1:0]       split_idx;
    logic [3:0]            split_be;
    logic [31:0]           split_wdata, split_word;

    logic                  wr_en;
    logic [IDXW-1:0]       wr_idx;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;

    logic [31:0]           ext_lo, ext_hi, ext_value;
    logic [1:0]            ext_lane, ext_size;
    logic                  ext_uns;

    // Shift the selected bytes down to bit 0, then sign- or zero-extend to 32 bits.
    function automatic logic [31:0] extract(input logic [63:0] pair, input logic [1:0] lane_sel,
                                            input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        logic [31:0] res;
        sh = 32'(pair >> {lane_sel, 3'b000});
        case (sz)
            2'b00:   res = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    assign in_split      = (state != IDLE);
    assign bus.req_ready = ready_q && !in_split;
    assign accept        = bus.req_valid && bus.req_ready;
    assign lane          = bus.req_addr[1:0];
    assign size          = bus.req_funct3[1:0];
    assign idx           = bus.req_addr[IDXW+1:2];
    assign addr_hi       = bus.req_addr >> (IDXW + 2);

    always_comb begin
        bad_op       = (size == 2'b11) || (bus.req_funct3[2] && size[1]) ||
                       (bus.req_we && bus.req_funct3[2]);
        out_of_range = (addr_hi != '0);
        crosses      = ((size == 2'b01) && (lane == 2'b11)) || ((size == 2'b10) && (lane != 2'b00));
`ifdef DMEM_MISALIGN_SPLIT_EN
        misalign     = 1'b0;
        span         = crosses;
        // No wrap-around: a spanning access into the last word has no second word.
        next_oob     = crosses && (&idx);
`else
        misalign     = crosses || ((size == 2'b01) && (lane == 2'b01));
        span         = 1'b0;
        next_oob     = 1'b0;
`endif
        fault        = bad_op || out_of_range || misalign || next_oob;
        go_split     = accept && span && !fault;
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        be8          = {4'b0000, size_mask} << lane;
        wdata64      = {32'h0, bus.req_wdata} << {lane, 3'b000};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = IDLE;
`ifdef DMEM_MISALIGN_SPLIT_EN
        if ((state == IDLE) && go_split) state_next = SPLIT;
`endif
    end

    // In SPLIT the load path sees {word A+1, held word A}; otherwise word A alone.
    always_comb begin
        ext_lo    = in_split ? split_word : mem[idx];
        ext_hi    = in_split ? mem[split_idx] : 32'h0;
        ext_lane  = in_split ? split_lane : lane;
        ext_size  = in_split ? split_size : size;
        ext_uns   = in_split ? split_uns : bus.req_funct3[2];
        ext_value = extract({ext_hi, ext_lo}, ext_lane, ext_size, ext_uns);
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = idx;
        wr_be   = be8[3:0];
        wr_data = wdata64[31:0];
        if (in_split) begin
            wr_en   = split_we;
            wr_idx  = split_idx;
            wr_be   = split_be;
            wr_data = split_wdata;
        end else if (accept && !fault && bus.req_we) begin
            wr_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q       <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_fault <= 1'b0;
            split_we      <= 1'b0;
            split_uns     <= 1'b0;
            split_lane    <= '0;
            split_size    <= '0;
            split_idx     <= '0;
            split_be      <= '0;
            split_wdata   <= '0;
            split_word    <= '0;
        end else begin
            ready_q       <= 1'b1;
            bus.rsp_valid <= 1'b0;
            if (accept) begin
                split_we    <= bus.req_we;
                split_uns   <= bus.req_funct3[2];
                split_lane  <= lane;
                split_size  <= size;
                split_idx   <= idx + IDXW'(1);
                split_be    <= be8[7:4];
                split_wdata <= wdata64[63:32];
                split_word  <= mem[idx];
            end
            if (in_split) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_fault <= 1'b0;
                bus.rsp_rdata <= split_we ? '0 : ext_value;
            end else if (accept && !go_split) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_fault <= fault;
                bus.rsp_rdata <= (fault || bus.req_we) ? '0 : ext_value;
            end
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomised and directed bench for data_mem_ctrl against a byte-array reference model.
// Honours DMEM_MISALIGN_SPLIT_EN so either build of the design can be checked.
module tb_data_mem_ctrl;
    localparam int MEM_WORDS = 64;
    localparam int MEM_BYTES = MEM_WORDS * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] ref_mem [MEM_BYTES];

    data_mem_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    // Expected response from the access rules, treating memory as a flat byte array.
    function automatic void model_predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                          output logic fault, output logic [31:0] rdata, output int lat);
        int     n;
        longint last;
        logic   spans;
        logic [31:0] raw;
        n     = nbytes(f3);
        fault = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (we && f3[2]);
        last  = longint'(addr) + n - 1;
        if (last >= MEM_BYTES) fault = 1'b1;
`ifdef DMEM_MISALIGN_SPLIT_EN
        spans = (longint'(addr) / 4) != (last / 4);
`else
        spans = 1'b0;
        if ((addr % n) != 0) fault = 1'b1;
`endif
        lat   = (spans && !fault) ? 2 : 1;
        rdata = 32'h0;
        if (!fault && !we) begin
            raw = 32'h0;
            for (int k = 0; k < n; k++) raw = raw | (32'(ref_mem[int'(addr) + k]) << (8 * k));
            case (f3)
                3'b000:  rdata = {{24{raw[7]}}, raw[7:0]};
                3'b001:  rdata = {{16{raw[15]}}, raw[15:0]};
                default: rdata = raw;
            endcase
        end
    endfunction

    function automatic void model_commit(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
        for (int k = 0; k < nbytes(f3); k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
    endfunction

    // Drive one request at a falling edge and collect its response (bounded wait).
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic got, output logic fault, output logic [31:0] rdata, output int lat,
                         output logic rdy_acc, output logic rdy_next);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        rdy_acc = bus.req_ready;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        got = 1'b0; fault = 1'b0; rdata = 32'h0; lat = 0; rdy_next = 1'b0;
        for (int c = 1; c <= 4 && !got; c++) begin
            @(negedge clk);
            if (c == 1) rdy_next = bus.req_ready;
            if (bus.rsp_valid) begin
                got = 1'b1; fault = bus.rsp_fault; rdata = bus.rsp_rdata; lat = c;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b want 0", bus.req_ready); end
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", bus.rsp_rdata); end
        vectors++; if (bus.rsp_fault !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rsp_fault: got %b want 0", bus.rsp_fault); end
        rst_n = 1'b1;
        #1;
        vectors++; if (bus.req_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ready_before_edge: got %b want 0", bus.req_ready); end
        @(posedge clk);
        #1;
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ready_after_edge: got %b want 1", bus.req_ready); end
    endtask

    task automatic test_preload();
        logic got, f, ra, rn; logic [31:0] rd, w; int lat;
        for (int i = 0; i < MEM_WORDS; i++) begin
            w = $urandom;
            issue(1'b1, 3'b010, 32'(i * 4), w, got, f, rd, lat, ra, rn);
            model_commit(3'b010, 32'(i * 4), w);
            vectors++; if (got !== 1'b1 || f !== 1'b0) begin miscompares++; $display("[TB] FAIL preload_%0d: got valid=%b fault=%b want valid=1 fault=0", i, got, f); end
        end
    endtask

    task automatic test_byte_loads();
        logic got, f, ra, rn; logic [31:0] rd; int lat;
        issue(1'b1, 3'b010, 32'h10, 32'h8765_43A1, got, f, rd, lat, ra, rn);
        model_commit(3'b010, 32'h10, 32'h8765_43A1);
        vectors++; if (got !== 1'b1 || lat != 1 || f !== 1'b0) begin miscompares++; $display("[TB] FAIL sw_0x10: got valid=%b lat=%0d fault=%b want 1/1/0", got, lat, f); end
        issue(1'b0, 3'b000, 32'h10, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== 32'hFFFF_FFA1 || lat != 1) begin miscompares++; $display("[TB] FAIL lb_0x10: got %h lat %0d want ffffffa1 lat 1", rd, lat); end
        issue(1'b0, 3'b100, 32'h10, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== 32'h0000_00A1 || lat != 1) begin miscompares++; $display("[TB] FAIL lbu_0x10: got %h lat %0d want 000000a1 lat 1", rd, lat); end
    endtask

    task automatic test_halfword();
        logic got, f, ra, rn, ef; logic [31:0] rd, er; int lat, el;
        issue(1'b1, 3'b001, 32'h22, 32'h1234_BEEF, got, f, rd, lat, ra, rn);
        model_commit(3'b001, 32'h22, 32'h1234_BEEF);
        model_predict(1'b0, 3'b010, 32'h20, ef, er, el);
        issue(1'b0, 3'b010, 32'h20, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== er || rd[31:16] !== 16'hBEEF) begin miscompares++; $display("[TB] FAIL lw_0x20: got %h want %h", rd, er); end
        issue(1'b0, 3'b001, 32'h22, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== 32'hFFFF_BEEF) begin miscompares++; $display("[TB] FAIL lh_0x22: got %h want ffffbeef", rd); end
        issue(1'b0, 3'b101, 32'h22, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== 32'h0000_BEEF) begin miscompares++; $display("[TB] FAIL lhu_0x22: got %h want 0000beef", rd); end
    endtask

    task automatic test_faults();
        logic got, f, ra, rn, ef; logic [31:0] rd, er; int lat, el;
        logic        f_we [5]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  f_f3 [5]   = '{3'b010, 3'b011, 3'b101, 3'b010, 3'b000};
        logic [31:0] f_addr [5] = '{32'(MEM_BYTES), 32'h10, 32'h20, 32'h8000_0010, 32'(MEM_BYTES + 3)};
        for (int i = 0; i < 5; i++) begin
            issue(f_we[i], f_f3[i], f_addr[i], 32'hDEAD_BEEF, got, f, rd, lat, ra, rn);
            vectors++; if (got !== 1'b1 || f !== 1'b1 || rd !== 32'h0 || lat != 1) begin miscompares++; $display("[TB] FAIL fault_%0d: got valid=%b fault=%b rdata=%h lat=%0d want 1/1/0/1", i, got, f, rd, lat); end
        end
        for (int a = 0; a < 3; a++) begin
            model_predict(1'b0, 3'b010, 32'(a * 16), ef, er, el);
            issue(1'b0, 3'b010, 32'(a * 16), 32'h0, got, f, rd, lat, ra, rn);
            vectors++; if (rd !== er || f !== 1'b0) begin miscompares++; $display("[TB] FAIL mem_unchanged_%0d: got %h want %h", a, rd, er); end
        end
        model_predict(1'b0, 3'b010, 32'(MEM_BYTES - 4), ef, er, el);
        issue(1'b0, 3'b010, 32'(MEM_BYTES - 4), 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== er) begin miscompares++; $display("[TB] FAIL last_word_unchanged: got %h want %h", rd, er); end
    endtask

    task automatic test_misalign();
        logic got, f, ra, rn, ef; logic [31:0] rd, er; int lat, el;
`ifdef DMEM_MISALIGN_SPLIT_EN
        issue(1'b1, 3'b010, 32'h0, 32'h4433_2211, got, f, rd, lat, ra, rn);
        model_commit(3'b010, 32'h0, 32'h4433_2211);
        issue(1'b1, 3'b010, 32'h4, 32'h8877_6655, got, f, rd, lat, ra, rn);
        model_commit(3'b010, 32'h4, 32'h8877_6655);
        issue(1'b0, 3'b010, 32'h2, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== 32'h6655_4433 || f !== 1'b0) begin miscompares++; $display("[TB] FAIL lw_0x02_split: got %h fault %b want 66554433 fault 0", rd, f); end
        vectors++; if (lat != 2 || rn !== 1'b0) begin miscompares++; $display("[TB] FAIL lw_0x02_timing: got lat %0d ready %b want lat 2 ready 0", lat, rn); end
        issue(1'b1, 3'b010, 32'(MEM_BYTES - 2), 32'hCAFE_F00D, got, f, rd, lat, ra, rn);
        vectors++; if (f !== 1'b1 || lat != 1) begin miscompares++; $display("[TB] FAIL sw_top_span: got fault %b lat %0d want fault 1 lat 1", f, lat); end
`else
        issue(1'b0, 3'b010, 32'h2, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (f !== 1'b1 || rd !== 32'h0 || lat != 1) begin miscompares++; $display("[TB] FAIL lw_0x02_fault: got fault %b rdata %h lat %0d want 1/0/1", f, rd, lat); end
        issue(1'b0, 3'b001, 32'h1, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (f !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("[TB] FAIL lh_0x01_fault: got fault %b rdata %h want 1/0", f, rd); end
`endif
        model_predict(1'b0, 3'b001, 32'h2, ef, er, el);
        issue(1'b0, 3'b001, 32'h2, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== er || f !== ef) begin miscompares++; $display("[TB] FAIL lh_0x02: got %h fault %b want %h fault %b", rd, f, er, ef); end
    endtask

    task automatic test_random();
        logic got, f, ra, rn, ef, we; logic [31:0] rd, er, addr, wdata; logic [2:0] f3; int lat, el, sel;
        logic [2:0] ok_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int n = 0; n < 300; n++) begin
            sel   = $urandom_range(0, 9);
            we    = 1'($urandom_range(0, 1));
            f3    = (sel == 0) ? 3'($urandom_range(0, 7)) : ok_f3[$urandom_range(0, 4)];
            if (sel <= 6)      addr = 32'($urandom_range(0, MEM_BYTES - 1));
            else if (sel <= 8) addr = 32'(MEM_BYTES - 4 + $urandom_range(0, 7));
            else               addr = $urandom;
            wdata = $urandom;
            model_predict(we, f3, addr, ef, er, el);
            issue(we, f3, addr, wdata, got, f, rd, lat, ra, rn);
            if (!ef && we) model_commit(f3, addr, wdata);
            vectors++;
            if (got !== 1'b1 || ra !== 1'b1 || f !== ef || rd !== er || lat != el || rn !== (el == 1)) begin
                miscompares++;
                $display("[TB] FAIL random_%0d we=%b f3=%b addr=%h: got valid=%b rdy=%b fault=%b rdata=%h lat=%0d rdy_next=%b want fault=%b rdata=%h lat=%0d",
                         n, we, f3, addr, got, ra, f, rd, lat, rn, ef, er, el);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ef; logic [31:0] er, addr, wdata; logic [2:0] f3; int el;
        logic [31:0] exp_q [$];
        addr = 32'h0;
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i > 0) begin
                er = exp_q.pop_front();
                vectors++; if (bus.rsp_valid !== 1'b1 || bus.rsp_fault !== 1'b0 || bus.rsp_rdata !== er) begin miscompares++; $display("[TB] FAIL b2b_rsp_%0d: got valid=%b fault=%b rdata=%h want 1/0/%h", i - 1, bus.rsp_valid, bus.rsp_fault, bus.rsp_rdata, er); end
            end
            vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ready_%0d: got %b want 1", i, bus.req_ready); end
            if (i < 10) begin
                if (i % 2 == 0) begin
                    addr  = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
                    f3    = 3'b010;
                    wdata = $urandom;
                end else begin
                    f3    = (i == 1) ? 3'b010 : (($urandom_range(0, 1) == 0) ? 3'b000 : 3'b101);
                end
                model_predict(i % 2 == 0, f3, addr, ef, er, el);
                if (i % 2 == 0) model_commit(f3, addr, wdata);
                exp_q.push_back(er);
                bus.req_valid  = 1'b1;
                bus.req_we     = (i % 2 == 0);
                bus.req_funct3 = f3;
                bus.req_addr   = addr;
                bus.req_wdata  = wdata;
            end else begin
                bus.req_valid = 1'b0;
            end
        end
        @(negedge clk);
        vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_tail: got valid %b want 0", bus.rsp_valid); end
    endtask

`ifdef DMEM_MISALIGN_SPLIT_EN
    task automatic test_split_reset();
        logic got, f, ra, rn, ef; logic [31:0] rd, er; int lat, el;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h6;
        bus.req_wdata  = 32'hA5B6_C7D8;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        ref_mem[6] = 8'hD8;
        ref_mem[7] = 8'hC7;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL split_reset_drop_%0d: got valid %b want 0", c, bus.rsp_valid); end
        end
        model_predict(1'b0, 3'b010, 32'h4, ef, er, el);
        issue(1'b0, 3'b010, 32'h4, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (got !== 1'b1 || ra !== 1'b1 || rd !== er) begin miscompares++; $display("[TB] FAIL split_reset_word1: got valid=%b rdy=%b rdata=%h want 1/1/%h", got, ra, rd, er); end
        model_predict(1'b0, 3'b010, 32'h8, ef, er, el);
        issue(1'b0, 3'b010, 32'h8, 32'h0, got, f, rd, lat, ra, rn);
        vectors++; if (rd !== er) begin miscompares++; $display("[TB] FAIL split_reset_word2: got %h want %h", rd, er); end
    endtask
`endif

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        test_reset();
        test_preload();
        test_byte_loads();
        test_halfword();
        test_faults();
        test_misalign();
        test_random();
        test_back_to_back();
`ifdef DMEM_MISALIGN_SPLIT_EN
        test_split_reset();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, handshaked data memory for the RV32 core's load/store path. Supports byte, halfword and word loads and stores, with sign- or zero-extension. Reads are registered with a fixed one-cycle response latency. Misaligned, out-of-range and unsupported accesses are detected and reported as faults instead of corrupting memory.

## Interface
- `DATA_WIDTH`, 32: data word width; only 32 is supported.
- `ADDR_WIDTH`, 32: byte address width.
- `MEM_WORDS`, 256: depth in 32-bit words; power of two, at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3; 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- `req_addr` in ADDR_WIDTH: byte address.
- `req_wdata` in DATA_WIDTH: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out DATA_WIDTH: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: access rejected; qualified by `rsp_valid`.

## Operation
- Accept on `req_valid && req_ready`. Request fields are sampled only at accept.
- Word index = `req_addr[ADDR_WIDTH-1:2]`; byte lane = `req_addr[1:0]`.
- Store lanes:
  - SB writes lane `addr[1:0]` from `wdata[7:0]`.
  - SH writes lanes `addr[1:0]` and `addr[1:0]+1` from `wdata[15:0]`, little-endian.
  - SW writes all four lanes.
  - Unselected bytes are unchanged.
- Load extension:
  - LB/LH sign-extend from bit 7/15 of the extracted field.
  - LBU/LHU zero-extend.
  - LW returns the word unchanged.
- Fault conditions. Any of these sets `rsp_fault=1` and `rsp_rdata=0`, with no memory write:
  - funct3 is 011, 110 or 111.
  - A store with funct3 100 or 101.
  - Word index ≥ `MEM_WORDS`. Index bits above log2(MEM_WORDS) must be zero; there is no wrap-around.
  - Misalignment, as defined under Configuration.
- Every accepted request produces exactly one `rsp_valid` pulse, including stores and faults.
- Memory contents are not reset. Control and output registers are reset.
- State machine:
  - IDLE: `req_ready=1`.
  - SPLIT: exists only with the macro; `req_ready=0`.
  - IDLE→SPLIT on accepting a spanning access. SPLIT→IDLE after one cycle.

## Timing
- Reset values: `rsp_valid=0`, `rsp_rdata=0`, `rsp_fault=0`, state IDLE.
- `req_ready` is 0 while `rst_n` is low and 1 from the first edge after deassertion.
- Single-word access:
  - Store commits at the accept edge.
  - Response is registered at the accept edge, so `rsp_valid` is high in cycle N+1.
- Throughput is one request per cycle. A new request may be accepted in the same cycle `rsp_valid` is high.
- Back-to-back store then load to the same address: the load returns the new data.
- Spanning access (macro on):
  - Accept edge N handles word A and its store lanes.
  - Edge N+1 handles word A+1.
  - `rsp_valid` is high in cycle N+2, and `req_ready=0` during cycle N+1.
- Range check for both words happens at accept. If word A+1 is out of range, the access faults at N+1 with no write to either word.
- Reset asserted during SPLIT:
  - State returns to IDLE.
  - The pending response is dropped.
  - A word-A store that already committed remains written.

## Configuration
- `DMEM_MISALIGN_SPLIT_EN` undefined:
  - Fault on any halfword with `addr[0]=1`.
  - Fault on any word with `addr[1:0]!=0`.
  - No SPLIT state; `req_ready` is constantly 1 outside reset.
- `DMEM_MISALIGN_SPLIT_EN` defined:
  - Misaligned accesses that fit in one word (halfword at lane 1) complete in one cycle.
  - Accesses spanning two words (halfword at lane 3; word at lane 1, 2 or 3) use SPLIT.
  - Byte order is little-endian across the word boundary.

## Test plan
- Reset, then SW 0x8765_43A1 @0x10; LB @0x10 → `rsp_rdata`=0xFFFF_FFA1; LBU → 0x0000_00A1, each exactly one cycle after accept.
- SH 0xBEEF @0x22, then LW @0x20 → upper half 0xBEEF, lower half unchanged. LH @0x22 → 0xFFFF_BEEF. LHU @0x22 → 0x0000_BEEF.
- Out-of-range and invalid cases, each → `rsp_fault=1`, `rdata=0`, memory unchanged:
  - SW @ MEM_WORDS*4.
  - funct3=011.
  - Store with funct3=101.
- LW @0x02:
  - Macro off → fault, one-cycle latency.
  - Macro on, after SW 0x4433_2211 @0x00 and SW 0x8877_6655 @0x04 → 0x6655_4433, two-cycle latency, `req_ready` low for one cycle.
- Ten back-to-back aligned requests with `req_valid` held high → ten `rsp_valid` pulses on consecutive cycles, `req_ready` never low.
- Macro on, SW @0x06 with `rst_n` pulsed low in SPLIT → no `rsp_valid`. Word 1 bytes 2–3 written; word 2 unchanged. Next request is accepted normally.
